// File: rtl/sram_responder.sv
// Dual-port word-array responder for the core's inst_sram/data_sram ports with
// window range checking and an error counter. `SRAM_INIT_CLEAR_EN enables the post-reset clear FSM.
module sram_responder #(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h1FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        mem_ready,
    output logic [15:0] err_cnt,
    output logic        dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] inst_idx, data_idx;
    logic                  inst_in_win, data_in_win;
    logic                  svc_active;
    logic                  inst_ok, data_ok, inst_oob, data_oob;
    logic [16:0]           err_sum;
    logic                  unused_addr_lsbs;

    assign inst_idx    = inst_sram_addr[DEPTH_LOG2+1:2];
    assign data_idx    = data_sram_addr[DEPTH_LOG2+1:2];
    assign inst_in_win = (inst_sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign data_in_win = (data_sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    // Lane selection is purely by wen; the byte offset bits carry no meaning here.
    assign unused_addr_lsbs = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

`ifdef SRAM_INIT_CLEAR_EN
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
    logic                  clr_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (&clr_idx_q) state_d = ST_READY;
            end
            default: ;
        endcase
    end

    assign svc_active = (state_q == ST_READY);
    assign dbg_state  = state_q;
`else
    assign svc_active = 1'b1;
    assign dbg_state  = 1'b1;
`endif

    assign mem_ready = svc_active;
    assign inst_ok   = svc_active && inst_sram_en && inst_in_win;
    assign data_ok   = svc_active && data_sram_en && data_in_win;
    assign inst_oob  = svc_active && inst_sram_en && !inst_in_win;
    assign data_oob  = svc_active && data_sram_en && !data_in_win;

    // Data-port lanes are written after inst-port lanes so the data port wins shared lanes.
    always_ff @(posedge clk) begin
`ifdef SRAM_INIT_CLEAR_EN
        if (clr_we) mem[clr_idx_q] <= '0;
`endif
        for (int b = 0; b < 4; b++) begin
            if (inst_ok && inst_sram_wen[b]) mem[inst_idx][8*b +: 8] <= inst_sram_wdata[8*b +: 8];
        end
        for (int b = 0; b < 4; b++) begin
            if (data_ok && data_sram_wen[b]) mem[data_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
        end else if (!svc_active) begin
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
        end else begin
            if (inst_sram_en) inst_sram_rdata <= inst_in_win ? mem[inst_idx] : '0;
            if (data_sram_en) data_sram_rdata <= data_in_win ? mem[data_idx] : '0;
        end
    end

    assign err_sum = {1'b0, err_cnt} + {16'd0, inst_oob} + {16'd0, data_oob};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_cnt <= '0;
        else      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (DEPTH_LOG2=4): clear, byte writes, collisions,
// window errors with saturation, hold and reset behaviour.
module tb_sram_responder;

    localparam int          DL2  = 4;
    localparam logic [31:0] BASE = 32'h1FC0_0000;
    localparam logic [31:0] OOB  = BASE + 32'h40;

    logic        clk, rst;
    logic        inst_sram_en, data_sram_en;
    logic [3:0]  inst_sram_wen, data_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        mem_ready, dbg_state;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_err;

    sram_responder #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .mem_ready(mem_ready), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata);
        inst_sram_en = en; inst_sram_wen = wen; inst_sram_addr = addr; inst_sram_wdata = wdata;
    endtask

    task automatic set_data(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata);
        data_sram_en = en; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
    endtask

    task automatic idle();
        set_inst(1'b0, 4'h0, 32'h0, 32'h0);
        set_data(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic run_init(input string tag);
`ifdef SRAM_INIT_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            check({tag, "_ready_low"}, {31'd0, mem_ready}, 32'd0);
            tick();
        end
        check({tag, "_ready_high"}, {31'd0, mem_ready}, 32'd1);
`else
        check({tag, "_ready_tied"}, {31'd0, mem_ready}, 32'd1);
`endif
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #12;
        check("rst_inst_rdata", inst_sram_rdata, 32'h0);
        check("rst_data_rdata", data_sram_rdata, 32'h0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'h0);
`ifdef SRAM_INIT_CLEAR_EN
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
`ifdef SRAM_INIT_CLEAR_EN
        // Requests during the clear must be ignored entirely.
        set_inst(1'b1, 4'hF, BASE, 32'hDEAD_BEEF);
        set_data(1'b1, 4'hF, OOB, 32'h1234_5678);
        run_init("init");
        check("init_err_cnt", {16'd0, err_cnt}, 32'h0);
        check("init_inst_rdata", inst_sram_rdata, 32'h0);
        check("init_dbg_state", {31'd0, dbg_state}, 32'd1);
        idle();
        for (int i = 0; i < 16; i++) begin
            set_data(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);
            tick();
            check($sformatf("clear_word%0d", i), data_sram_rdata, 32'h0);
        end
        idle();
`else
        run_init("init");
`endif

        // Byte-lane writes; the second write returns the first word (read-first).
        set_data(1'b1, 4'hF, BASE + 32'h8, 32'hAABB_CCDD); tick();
        set_data(1'b1, 4'b0101, BASE + 32'h8, 32'h1122_3344); tick();
        check("byte_readfirst", data_sram_rdata, 32'hAABB_CCDD);
        set_data(1'b1, 4'h0, BASE + 32'h8, 32'h0); tick();
        check("byte_merge", data_sram_rdata, 32'hAA22_CC44);

        // Same-word read/write collision.
        set_data(1'b1, 4'hF, BASE + 32'h10, 32'h5); tick();
        set_inst(1'b1, 4'h0, BASE + 32'h10, 32'h0);
        set_data(1'b1, 4'hF, BASE + 32'h10, 32'h9); tick();
        check("coll_inst_old", inst_sram_rdata, 32'h5);
        check("coll_data_old", data_sram_rdata, 32'h5);
        set_data(1'b0, 4'h0, 32'h0, 32'h0); tick();
        check("coll_new", inst_sram_rdata, 32'h9);

        // Both ports write overlapping lanes of one word.
        idle();
        set_data(1'b1, 4'hF, BASE + 32'h14, 32'hA5A5_A5A5); tick();
        set_inst(1'b1, 4'b0011, BASE + 32'h14, 32'h1111_1111);
        set_data(1'b1, 4'b0110, BASE + 32'h14, 32'h2222_2222); tick();
        idle();
        set_inst(1'b1, 4'h0, BASE + 32'h14, 32'h0); tick();
        check("lane_priority", inst_sram_rdata, 32'hA522_2211);
        check("lane_hold_data", data_sram_rdata, 32'hA5A5_A5A5);

        // Out-of-window: zero rdata, dropped write, error counting.
        idle();
        exp_err = 16'd0;
        set_data(1'b1, 4'h0, OOB, 32'h0); tick(); exp_err = 16'd1;
        check("oob_rdata", data_sram_rdata, 32'h0);
        check("oob_err1", {16'd0, err_cnt}, {16'd0, exp_err});
        set_data(1'b1, 4'hF, OOB + 32'h8, 32'hFFFF_FFFF); tick(); exp_err = 16'd2;
        set_data(1'b1, 4'h0, BASE + 32'h8, 32'h0); tick();
        check("oob_write_dropped", data_sram_rdata, 32'hAA22_CC44);
        set_inst(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        set_data(1'b1, 4'h0, OOB, 32'h0); tick(); exp_err = 16'd4;
        check("oob_both_err", {16'd0, err_cnt}, {16'd0, exp_err});
        check("oob_inst_rdata", inst_sram_rdata, 32'h0);

        // Drive both ports out of window until the counter sits just below saturation.
        while (exp_err < 16'hFFFE) begin
            tick();
            exp_err = exp_err + 16'd2;
        end
        check("sat_pre", {16'd0, err_cnt}, 32'h0000_FFFE);
        tick();
        check("sat_both", {16'd0, err_cnt}, 32'h0000_FFFF);
        set_inst(1'b0, 4'h0, 32'h0, 32'h0); tick();
        check("sat_single", {16'd0, err_cnt}, 32'h0000_FFFF);

        // Hold: en=0 keeps rdata and ignores wen.
        idle();
        set_data(1'b1, 4'hF, BASE + 32'h1C, 32'h7); tick();
        set_data(1'b1, 4'h0, BASE + 32'h1C, 32'h0); tick();
        check("hold_read", data_sram_rdata, 32'h7);
        for (int i = 0; i < 3; i++) begin
            set_data(1'b0, 4'hF, BASE + 32'h8, 32'h0BAD_0BAD); tick();
            check($sformatf("hold_cyc%0d", i), data_sram_rdata, 32'h7);
        end
        set_data(1'b1, 4'h0, BASE + 32'h8, 32'h0); tick();
        check("hold_no_write", data_sram_rdata, 32'hAA22_CC44);
        check("hold_err", {16'd0, err_cnt}, 32'h0000_FFFF);

        // Reset from READY: outputs clear asynchronously.
        idle();
        rst = 1'b0; #1;
        check("rerst_data_rdata", data_sram_rdata, 32'h0);
        check("rerst_err_cnt", {16'd0, err_cnt}, 32'h0);
`ifdef SRAM_INIT_CLEAR_EN
        check("rerst_ready", {31'd0, mem_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (9) tick();
        check("mid_init_ready", {31'd0, mem_ready}, 32'd0);
        rst = 1'b0; #1;
        check("mid_init_rst_err", {16'd0, err_cnt}, 32'h0);
        check("mid_init_rst_rdata", inst_sram_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_init("reinit");
`else
        check("rerst_ready", {31'd0, mem_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        check("rerst_ready_after", {31'd0, mem_ready}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
